clock_12hr_counter: RTL and testbench

// - Timekeeping stage directly upstream of the alarm FSM.
// - Divides the system clock to a 1 Hz tick and counts seconds, minutes and hours in 12-hour format with AM/PM.
// - Drives the alarm FSM's clock_minutes_pi / clock_hours_pi inputs.
// - Provides a set-time mode driven by single-cycle increment pulses from the button conditioning logic.
//

---
 rtl/clock_12hr_counter.sv | 115 +++++++++++
 tb/tb_clock_12hr_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_12hr_counter.sv
// 12-hour clock with AM/PM flag. It divides clk_pi down to a 1 Hz second
// event and counts seconds, minutes and hours. In set-time mode counting is
// frozen and single-cycle increment pulses adjust minutes and hours directly.
module clock_12hr_counter #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk_pi,
  input  logic       rst_n_pi,
  input  logic       set_en_pi,
  input  logic       increment_minute_pi,
  input  logic       increment_hour_pi,
  output logic [5:0] seconds_po,
  output logic [5:0] minutes_po,
  output logic [3:0] hours_po,
  output logic       pm_po,
  output logic       sec_tick_po,
  output logic       minute_tick_po
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [3:0]    hr_q, hr_d;
  logic          pm_q, pm_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_tick_q, min_tick_d;
  logic          hour_step;

  // Next-state: run-mode cascade or set-mode increments, then the hour rule.
  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    pm_d       = pm_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    hour_step  = 1'b0;

    if (set_en_pi) begin
      presc_d = '0;
      sec_d   = '0;
      if (increment_minute_pi) begin
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
      hour_step = increment_hour_pi;
    end else if (presc_q == PRESC_MAX) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d      = '0;
        min_tick_d = 1'b1;
        if (min_q == 6'd59) begin
          min_d     = '0;
          hour_step = 1'b1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // AM/PM flips on entering 12, not on leaving it.
    if (hour_step) begin
      if (hr_q == 4'd11) begin
        hr_d = 4'd12;
        pm_d = ~pm_q;
      end else if (hr_q == 4'd12) begin
        hr_d = 4'd1;
      end else begin
        hr_d = hr_q + 4'd1;
      end
    end

    // Recover from any corrupted hour value.
    if (hr_q == 4'd0 || hr_q > 4'd12) begin
      hr_d = 4'd12;
    end
  end

  // State register; reset time is 12:00:00 AM.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= 4'd12;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
    end
  end

  assign seconds_po     = sec_q;
  assign minutes_po     = min_q;
  assign hours_po       = hr_q;
  assign pm_po          = pm_q;
  assign sec_tick_po    = sec_tick_q;
  assign minute_tick_po = min_tick_q;

endmodule

// File: tb/tb_clock_12hr_counter.sv
// Bench for clock_12hr_counter. The reference keeps time of day as a count of
// seconds since midnight plus a prescaler phase; display fields are derived
// arithmetically from that count.
module tb_clock_12hr_counter;

  localparam int unsigned TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_en;
  logic       inc_min;
  logic       inc_hour;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [3:0] hours;
  logic       pm;
  logic       sec_tick;
  logic       min_tick;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int tod = 0;   // seconds since 12:00:00 AM, 0..86399
  int pc  = 0;   // prescaler phase
  int exp_st = 0;
  int exp_mt = 0;

  clock_12hr_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk_pi              (clk),
    .rst_n_pi            (rst_n),
    .set_en_pi           (set_en),
    .increment_minute_pi (inc_min),
    .increment_hour_pi   (inc_hour),
    .seconds_po          (seconds),
    .minutes_po          (minutes),
    .hours_po            (hours),
    .pm_po               (pm),
    .sec_tick_po         (sec_tick),
    .minute_tick_po      (min_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int m_sec();  return tod % 60;          endfunction
  function automatic int m_min();  return (tod / 60) % 60;   endfunction
  function automatic int m_h24();  return tod / 3600;        endfunction
  function automatic int m_pm();   return (m_h24() >= 12) ? 1 : 0; endfunction
  function automatic int m_hour();
    int h;
    h = m_h24() % 12;
    return (h == 0) ? 12 : h;
  endfunction

  task automatic model_reset();
    tod = 0; pc = 0; exp_st = 0; exp_mt = 0;
  endtask

  task automatic model_step(input bit s, input bit im, input bit ih);
    int m, h;
    exp_st = 0;
    exp_mt = 0;
    if (s) begin
      pc  = 0;
      tod = tod - (tod % 60);
      if (im) begin
        m   = m_min();
        tod = tod + (((m + 1) % 60) - m) * 60;
      end
      if (ih) begin
        h   = m_h24();
        tod = tod + (((h + 1) % 24) - h) * 3600;
      end
    end else if (pc == TPS - 1) begin
      pc     = 0;
      tod    = (tod + 1) % 86400;
      exp_st = 1;
      exp_mt = (tod % 60 == 0) ? 1 : 0;
    end else begin
      pc++;
    end
  endtask

  task automatic compare_all();
    check("seconds", int'(seconds), m_sec());
    check("minutes", int'(minutes), m_min());
    check("hours", int'(hours), m_hour());
    check("pm", int'(pm), m_pm());
    check("sec_tick", int'(sec_tick), exp_st);
    check("minute_tick", int'(min_tick), exp_mt);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic cycle(input bit s, input bit im, input bit ih);
    set_en = s; inc_min = im; inc_hour = ih;
    @(posedge clk); #1;
    model_step(s, im, ih);
    compare_all();
  endtask

  task automatic set_time(input int h24, input int mn);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30 && m_h24() != h24; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 70 && m_min() != mn; i++) cycle(1'b1, 1'b1, 1'b0);
    check("set_h24", m_h24(), h24);
    check("set_min", m_min(), mn);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_time(input string tag, input int h, input int mn, input int s, input int p);
    check({tag, "_h"}, int'(hours), h);
    check({tag, "_m"}, int'(minutes), mn);
    check({tag, "_s"}, int'(seconds), s);
    check({tag, "_pm"}, int'(pm), p);
  endtask

  task automatic first_tick_latency();
    int n;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (sec_tick) n = i;
    end
    check("first_tick_latency", n, TPS);
  endtask

  initial begin
    int mt_cnt, co_cnt, seg, mode;
    rst_n = 1'b0; set_en = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_time("reset", 12, 0, 0, 0);
    check("reset_stick", int'(sec_tick), 0);
    check("reset_mtick", int'(min_tick), 0);
    rst_n = 1'b1;
    first_tick_latency();

    // Minute rollover 10:59 -> 11:00 AM
    set_time(10, 59);
    mt_cnt = 0; co_cnt = 0;
    for (int i = 0; i < 60 * TPS; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (min_tick) mt_cnt++;
      if (min_tick && sec_tick) co_cnt++;
    end
    check("rollover_mtick_count", mt_cnt, 1);
    check("rollover_mtick_coincident", co_cnt, 1);
    check_time("rollover", 11, 0, 0, 0);

    // Midnight cascade from 11:59 PM
    set_time(23, 59);
    run_cycles(60 * TPS);
    check_time("midnight", 12, 0, 0, 0);

    // Noon, then one more hour
    set_time(11, 59);
    run_cycles(59 * TPS);
    check_time("pre_noon", 11, 59, 59, 0);
    run_cycles(TPS);
    check_time("noon", 12, 0, 0, 1);
    run_cycles(3600 * TPS);
    check_time("one_pm", 1, 0, 0, 1);

    // Set mode from 12:58 AM
    set_time(0, 58);
    check_time("set_start", 12, 58, 0, 0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check_time("set_result", 1, 2, 0, 0);

    // Increments ignored in run mode
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    check_time("run_incr_ignored", 1, 2, 0, 0);

    // Asynchronous reset mid-prescale, checked before the next edge
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_time("async_reset", 12, 0, 0, 0);
    check("async_reset_stick", int'(sec_tick), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    first_tick_latency();

    // Random mix of set/run segments with stray pulses
    for (int k = 0; k < 80; k++) begin
      seg  = $urandom_range(40, 1);
      mode = ($urandom_range(2, 0) == 0) ? 1 : 0;
      for (int i = 0; i < seg; i++)
        cycle(mode[0], ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
